sm_hex_display_scan: RTL and testbench

Frame-synchronous scan controller for the board's 8-digit common-anode seven-segment display. It accepts a 32-bit value and per-digit dot flags over a valid/ready port and double-buffers them. Digits are time-multiplexed with a programmable dwell time and a one-clock anti-ghosting blank between digits. New values are applied only at frame boundaries, so a displayed frame never mixes old and new digits. The block sits between the CPU-side I/O register and the display pins, and replaces free-running per-clock digit cycling.

---
 rtl/sm_hex_display_scan_if.sv | 25 ++
 rtl/sm_hex_display_scan.sv | 175 +++++++++++++++++
 tb/tb_sm_hex_display_scan.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sm_hex_display_scan_if.sv
// Write port of the hex display scan controller.
//   wr_valid   requester has a new value
//   wr_ready   pending buffer is empty; a write is accepted on wr_valid & wr_ready
//   wr_number  32-bit hex value, nibble k drives digit k (digit 0 = rightmost)
//   wr_dots    per-digit decimal point flags, bit k lights dot k
interface sm_hex_display_scan_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_number;
    logic [7:0]  wr_dots;

    modport master (
        output wr_valid,
        output wr_number,
        output wr_dots,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_number,
        input  wr_dots,
        output wr_ready
    );
endinterface

// File: rtl/sm_hex_display_scan.sv
// Frame-synchronous scan controller for an 8-digit common-anode seven-segment display.
// A written value is held in a pending buffer and promoted to the displayed buffer only at a
// frame boundary, so one frame never mixes old and new digits. Each digit slot is a one-clock
// anti-ghosting blank followed by a programmable dwell.
//
// Ports:
//   clock            system clock, rising edge
//   resetn           synchronous active-low reset
//   wr               write port (slave side): valid/ready, number, dots
//   cfg_prescale     dwell per digit = cfg_prescale + 1 clocks
//   cfg_enable_mask  digit k is driven only when bit k = 1
//   cfg_blank_lz     1 = blank leading zeros
//   seven_segments   {g,f,e,d,c,b,a}, active-low, registered
//   dot              decimal point, active-low, registered
//   anodes           digit select, active-low, registered
//   frame_done       one-clock pulse following each frame boundary, registered
module sm_hex_display_scan #(
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                  clock,
    input  logic                  resetn,
    sm_hex_display_scan_if.slave  wr,
    input  logic [PRESCALE_W-1:0] cfg_prescale,
    input  logic [7:0]            cfg_enable_mask,
    input  logic                  cfg_blank_lz,
    output logic [6:0]            seven_segments,
    output logic                  dot,
    output logic [7:0]            anodes,
    output logic                  frame_done
);

    typedef enum logic [0:0] {StBlank, StDrive} state_e;

    state_e                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic                  boundary;

    logic [31:0] active_num_q;
    logic [7:0]  active_dots_q;
    logic [31:0] pend_num_q;
    logic [7:0]  pend_dots_q;
    logic        pend_full_q;
    logic        accept;

    logic [6:0] seg_q, seg_d;
    logic       dot_q, dot_d;
    logic [7:0] anodes_q, anodes_d;
    logic       frame_done_q;

    // upper_zero[k]: nibbles k..7 of the displayed value are all zero
    logic [7:0] upper_zero;
    logic       digit_lit;
    logic [3:0] nibble;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0011000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    assign accept      = wr.wr_valid & ~pend_full_q;
    assign wr.wr_ready = ~pend_full_q;

    // State register and buffers
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q       <= StBlank;
            idx_q         <= 3'd0;
            cnt_q         <= '0;
            active_num_q  <= 32'd0;
            active_dots_q <= 8'd0;
            pend_num_q    <= 32'd0;
            pend_dots_q   <= 8'd0;
            pend_full_q   <= 1'b0;
            seg_q         <= 7'h7F;
            dot_q         <= 1'b1;
            anodes_q      <= 8'hFF;
            frame_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            seg_q        <= seg_d;
            dot_q        <= dot_d;
            anodes_q     <= anodes_d;
            frame_done_q <= boundary;
            // A write and a promotion never coincide: accept needs the pending slot empty.
            if (accept) begin
                pend_num_q  <= wr.wr_number;
                pend_dots_q <= wr.wr_dots;
                pend_full_q <= 1'b1;
            end else if (boundary && pend_full_q) begin
                active_num_q  <= pend_num_q;
                active_dots_q <= pend_dots_q;
                pend_full_q   <= 1'b0;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        boundary = 1'b0;
        case (state_q)
            StBlank: begin
                state_d = StDrive;
                cnt_d   = cfg_prescale;
            end
            StDrive: begin
                if (cnt_q == '0) begin
                    state_d  = StBlank;
                    idx_d    = idx_q + 3'd1;
                    boundary = (idx_q == 3'd7);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StBlank;
        endcase
    end

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            upper_zero[k] = ((active_num_q >> (4 * k)) == 32'd0);
        end
    end

    // Output logic: outputs are computed on the BLANK-to-DRIVE edge (sampling config there),
    // held through the dwell and forced off on entry to BLANK.
    always_comb begin
        seg_d     = 7'h7F;
        dot_d     = 1'b1;
        anodes_d  = 8'hFF;
        nibble    = active_num_q[{idx_q, 2'b00} +: 4];
        digit_lit = cfg_enable_mask[idx_q] &
                    ~(cfg_blank_lz & (idx_q != 3'd0) & upper_zero[idx_q]);
        if (state_q == StBlank) begin
            if (digit_lit) begin
                seg_d    = hex_to_seg(nibble);
                dot_d    = ~active_dots_q[idx_q];
                anodes_d = ~(8'd1 << idx_q);
            end
        end else if (state_d == StDrive) begin
            seg_d    = seg_q;
            dot_d    = dot_q;
            anodes_d = anodes_q;
        end
    end

    assign seven_segments = seg_q;
    assign dot            = dot_q;
    assign anodes         = anodes_q;
    assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_sm_hex_display_scan.sv
module tb_sm_hex_display_scan;

    localparam int unsigned PW = 16;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic [PW-1:0] cfg_prescale;
    logic [7:0]    cfg_enable_mask;
    logic          cfg_blank_lz;
    logic [6:0]    seven_segments;
    logic          dot;
    logic [7:0]    anodes;
    logic          frame_done;

    int checks = 0;
    int errors = 0;
    int cur_p;

    // Expected {anodes, segments, dot} per digit slot, in display order
    logic [15:0] sb_q[$];

    always #5 clock = ~clock;

    sm_hex_display_scan_if wr_if ();

    sm_hex_display_scan #(
        .PRESCALE_W(PW)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .wr             (wr_if),
        .cfg_prescale   (cfg_prescale),
        .cfg_enable_mask(cfg_enable_mask),
        .cfg_blank_lz   (cfg_blank_lz),
        .seven_segments (seven_segments),
        .dot            (dot),
        .anodes         (anodes),
        .frame_done     (frame_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [3:0] n);
        logic [6:0] tbl [16];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return tbl[n];
    endfunction

    function automatic logic [15:0] exp_slot(input logic [31:0] num, input logic [7:0] dots,
                                             input logic [7:0] mask, input logic lz,
                                             input int k);
        logic       lit;
        logic [7:0] an;
        lit = mask[k];
        if (lz && k > 0 && (num >> (4 * k)) == 32'd0) lit = 1'b0;
        an = 8'hFF;
        an[k] = 1'b0;
        if (lit) return {an, exp_seg(num[4 * k +: 4]), ~dots[k]};
        return 16'hFFFF;
    endfunction

    task automatic push_frame(input logic [31:0] num, input logic [7:0] dots);
        for (int k = 0; k < 8; k++) begin
            sb_q.push_back(exp_slot(num, dots, cfg_enable_mask, cfg_blank_lz, k));
        end
    endtask

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic write_word(input logic [31:0] num, input logic [7:0] dots, input bit hold);
        bit done = 1'b0;
        wr_if.wr_number = num;
        wr_if.wr_dots   = dots;
        wr_if.wr_valid  = 1'b1;
        for (int i = 0; i < 800 && !done; i++) begin
            if (wr_if.wr_ready) done = 1'b1;
            @(negedge clock);
        end
        check_eq("write_accept", {31'd0, done}, 32'd1);
        push_frame(num, dots);
        if (!hold) wr_if.wr_valid = 1'b0;
    endtask

    // Advance to the next boundary at which the pending buffer is empty.
    task automatic wait_active();
        bit found = 1'b0;
        for (int i = 0; i < 800 && !found; i++) begin
            @(negedge clock);
            if (frame_done && wr_if.wr_ready) found = 1'b1;
        end
        check_eq("wait_active", {31'd0, found}, 32'd1);
    endtask

    // Called at the frame_done negedge; captures one full frame and ends on the next one.
    task automatic capture_frame();
        logic [15:0] first;
        logic [15:0] exp;
        bit          stable;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            first  = {anodes, seven_segments, dot};
            stable = 1'b1;
            for (int c = 0; c < cur_p; c++) begin
                @(negedge clock);
                if ({anodes, seven_segments, dot} !== first) stable = 1'b0;
            end
            @(negedge clock);
            check_eq($sformatf("blank%0d", k), {anodes, seven_segments, dot}, 32'hFFFF);
            check_eq($sformatf("frame_done%0d", k), {31'd0, frame_done}, (k == 7) ? 1 : 0);
            check_eq($sformatf("stable%0d", k), {31'd0, stable}, 32'd1);
            if (sb_q.size() == 0) begin
                check_eq($sformatf("sb_underflow%0d", k), 32'd0, 32'd1);
            end else begin
                exp = sb_q.pop_front();
                check_eq($sformatf("slot%0d", k), first, exp);
            end
        end
    endtask

    initial begin
        int n4;
        int n5;
        bit found;
        logic [31:0] val_a;
        logic [31:0] val_b;

        cfg_prescale    = 16'd3;
        cur_p           = 3;
        cfg_enable_mask = 8'hFF;
        cfg_blank_lz    = 1'b0;
        wr_if.wr_valid  = 1'b1;
        wr_if.wr_number = 32'h12345678;
        wr_if.wr_dots   = 8'hFF;
        resetn          = 1'b0;

        // Reset with a write offered
        @(negedge clock);
        check_eq("rst_seg", {25'd0, seven_segments}, 32'h7F);
        check_eq("rst_dot", {31'd0, dot}, 32'd1);
        check_eq("rst_anodes", {24'd0, anodes}, 32'hFF);
        check_eq("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check_eq("rst_ready", {31'd0, wr_if.wr_ready}, 32'd1);
        repeat (2) @(negedge clock);
        check_eq("rst_no_accept", {31'd0, wr_if.wr_ready}, 32'd1);
        wr_if.wr_valid = 1'b0;
        resetn         = 1'b1;
        @(negedge clock);
        check_eq("first_drive", {anodes, seven_segments, dot}, {8'hFE, 7'b1000000, 1'b1});

        // Basic scan
        write_word(32'h89ABCDEF, 8'h00, 1'b0);
        wait_active();
        capture_frame();

        // Double buffer / backpressure
        val_a = 32'hA5A5A5A5;
        val_b = 32'h5A5A5A5A;
        write_word(val_a, 8'h0F, 1'b1);
        check_eq("db_ready_low", {31'd0, wr_if.wr_ready}, 32'd0);
        wr_if.wr_number = val_b;
        wr_if.wr_dots   = 8'hF0;
        found = 1'b0;
        for (int i = 0; i < 800 && !found; i++) begin
            if (wr_if.wr_ready) found = 1'b1;
            else @(negedge clock);
        end
        check_eq("db_stall_end", {31'd0, found}, 32'd1);
        check_eq("db_release_at_boundary", {31'd0, frame_done}, 32'd1);
        fork
            capture_frame();
            begin
                @(negedge clock);
                check_eq("db_b_accepted", {31'd0, wr_if.wr_ready}, 32'd0);
                wr_if.wr_valid = 1'b0;
                push_frame(val_b, 8'hF0);
            end
        join
        wait_active();
        capture_frame();

        // Leading-zero blanking
        cfg_blank_lz = 1'b1;
        write_word(32'h00000100, 8'h81, 1'b0);
        wait_active();
        capture_frame();
        write_word(32'h00000000, 8'h00, 1'b0);
        wait_active();
        capture_frame();

        // Enable mask
        cfg_blank_lz    = 1'b0;
        cfg_enable_mask = 8'h05;
        write_word(32'h12345678, 8'hFF, 1'b0);
        wait_active();
        capture_frame();
        cfg_enable_mask = 8'hFF;

        // Prescale change mid-dwell on digit 4
        wait_active();
        repeat (21) @(negedge clock);
        check_eq("md_digit4", {24'd0, anodes}, 32'hEF);
        cfg_prescale = 16'd0;
        n4 = 0;
        for (int i = 0; i < 20; i++) begin
            if (anodes != 8'hEF) break;
            n4++;
            @(negedge clock);
        end
        check_eq("md_dwell4", n4, 32'd4);
        @(negedge clock);
        n5 = 0;
        for (int i = 0; i < 20; i++) begin
            if (anodes != 8'hDF) break;
            n5++;
            @(negedge clock);
        end
        check_eq("md_dwell5", n5, 32'd1);
        cur_p = 0;

        // Reset mid-DRIVE with a pending write
        write_word(32'hDEADBEEF, 8'hAA, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clock);
            if (anodes != 8'hFF) found = 1'b1;
        end
        check_eq("mr_in_drive", {31'd0, found}, 32'd1);
        resetn = 1'b0;
        @(negedge clock);
        check_eq("mr_seg", {25'd0, seven_segments}, 32'h7F);
        check_eq("mr_dot", {31'd0, dot}, 32'd1);
        check_eq("mr_anodes", {24'd0, anodes}, 32'hFF);
        check_eq("mr_frame_done", {31'd0, frame_done}, 32'd0);
        check_eq("mr_ready", {31'd0, wr_if.wr_ready}, 32'd1);
        sb_q.delete();
        resetn = 1'b1;
        push_frame(32'd0, 8'd0);
        wait_active();
        capture_frame();

        check_eq("sb_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
